m_wb_uart_rx: RTL

Hardware 8N1 UART receiver and Wishbone slave. It replaces the software-sampled RX path of the bitbang UART on the icebreaker top. It sits between the RX pin and the midgetv core read-data mux. It oversamples the line with a fixed clock divisor and buffers received bytes in a small FIFO. The core pops bytes with single-cycle Wishbone reads instead of polling individual bit times.

---
 rtl/m_wb_uart_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/m_wb_uart_rx.sv
// 8N1 UART receiver with a small byte FIFO, popped by zero-wait Wishbone reads; frame to FIFO ~2+CLKDIV/2+9*CLKDIV clocks.
// No backpressure on the line: a byte arriving with the FIFO full is dropped and flagged as overrun.
module m_wb_uart_rx #(
    parameter int CLKDIV = 104,
    parameter int FIFOAW = 2
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        usartRX,
    output logic        rxne
);
    localparam int CW    = $clog2(CLKDIV);
    localparam int DEPTH = 1 << FIFOAW;
    localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKDIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sync1, r_rxs;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shreg;
    logic [7:0]        r_mem [DEPTH];
    logic [FIFOAW:0]   r_wp, r_rp;
    logic              r_ferr, r_ovr, r_rxne;

    logic w_tick, w_load_half, w_load_full, w_bit_clr, w_shift, w_push, w_ferr_set;
    logic w_empty, w_full, w_rd, w_flush, w_pop, w_wr, w_ovr_set;
    logic [7:0] w_head;

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= usartRX;
            r_rxs   <= r_sync1;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: if (!r_rxs) begin
                w_load_half = 1'b1;
                w_state_nxt = S_START;
            end
            // A start bit that is high again at its mid-point is a glitch.
            S_START: if (w_tick) begin
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_load_full = 1'b1;
                    w_bit_clr   = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: if (w_tick) begin
                w_shift     = 1'b1;
                w_load_full = 1'b1;
                if (r_bitcnt == 3'd7) w_state_nxt = S_STOP;
            end
            S_STOP: if (w_tick) begin
                if (r_rxs) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ferr_set  = 1'b1;
                    w_state_nxt = S_BREAK;
                end
            end
            S_BREAK: if (r_rxs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
        end else begin
            if (w_load_half)      r_cnt <= HALF;
            else if (w_load_full) r_cnt <= FULL;
            else if (!w_tick)     r_cnt <= r_cnt - 1'b1;
            if (w_bit_clr)        r_bitcnt <= '0;
            else if (w_shift)     r_bitcnt <= r_bitcnt + 1'b1;
            if (w_shift)          r_shreg <= {r_rxs, r_shreg[7:1]};
        end
    end

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[FIFOAW] != r_rp[FIFOAW]) &&
                       (r_wp[FIFOAW-1:0] == r_rp[FIFOAW-1:0]);
    assign w_rd      = STB_I & ~WE_I;
    assign w_flush   = STB_I & WE_I & DAT_I;
    assign w_pop     = w_rd & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_wr      = w_push & (~w_full | w_pop) & ~w_flush;
    assign w_ovr_set = w_push & w_full & ~w_pop;

    always_ff @(posedge CLK_I) begin
        if (w_wr) r_mem[r_wp[FIFOAW-1:0]] <= r_shreg;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            r_rxne <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rp <= r_wp;
            end else begin
                if (w_wr)  r_wp <= r_wp + 1'b1;
                if (w_pop) r_rp <= r_rp + 1'b1;
            end
            // Set beats clear so an error landing on the clearing read is not lost.
            r_ferr <= w_ferr_set | (r_ferr & ~(w_rd | w_flush));
            r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_rd | w_flush));
            r_rxne <= ~w_empty;
        end
    end

    assign w_head = w_empty ? 8'h00 : r_mem[r_rp[FIFOAW-1:0]];
    assign DAT_O  = w_rd ? {21'b0, r_ovr, r_ferr, ~w_empty, w_head} : 32'b0;
    assign ACK_O  = STB_I;
    assign rxne   = r_rxne;
endmodule
